// File: rtl/phy_lane_pattern_checker.sv
// ---------------------------------------------------------------------------
// phy_lane_pattern_checker
//   Multi-lane PHY traffic generator and checker.
//   The generator emits bursts of burst_len valid words per lane on paralelo,
//   with optional invalid gap words. The checker compares every valid word
//   returned on data_in against its own expected sequence, which is generated
//   independently of the transmit side, and counts errors and received words.
//
//   Word format per lane: bit DATA_W is the valid flag, bits DATA_W-1:0 are
//   data. Lane i occupies bits [i*(DATA_W+1) +: DATA_W+1].
//
//   Optional build macro: PHY_GEN_PRBS_EN
//     undefined : increment pattern, lane i seeded with i mod 2^DATA_W
//     defined   : 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1 on data[7:0],
//                 lane i seeded with i+1, upper data bits 0 (DATA_W >= 8)
//
// Ports
//   clkf       in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle start pulse (ignored in RUN or with burst_len=0)
//   burst_len  in   valid words per lane per burst
//   paralelo   out  generated lane words (registered)
//   data_in    in   returned lane words, same packing
//   busy       out  high while burst words are being presented
//   done       out  high after a burst completes until next start/reset
//   err_flag   out  sticky mismatch flag
//   err_count  out  mismatching valid words, saturating
//   rx_count   out  valid words received over all lanes, saturating
// ---------------------------------------------------------------------------
module phy_lane_pattern_checker #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_PERIOD = 0,
    parameter int ERR_W      = 16,
    parameter int RX_W       = 24
) (
    input  logic                          clkf,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   burst_len,
    output logic [LANES*(DATA_W+1)-1:0]   paralelo,
    input  logic [LANES*(DATA_W+1)-1:0]   data_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err_flag,
    output logic [ERR_W-1:0]              err_count,
    output logic [RX_W-1:0]               rx_count
);

    localparam int WW      = DATA_W + 1;
    localparam int CW      = $clog2(LANES + 1);
    localparam int GW      = (GAP_PERIOD > 1) ? $clog2(GAP_PERIOD) : 1;
    localparam int GP_LAST = (GAP_PERIOD > 0) ? GAP_PERIOD - 1 : 0;
    localparam int EW      = ((ERR_W > CW) ? ERR_W : CW) + 1;
    localparam int RW      = ((RX_W > CW) ? RX_W : CW) + 1;

`ifdef PHY_GEN_PRBS_EN
    if (DATA_W < 8) begin : g_prbs_width_check
        $error("PHY_GEN_PRBS_EN requires DATA_W >= 8");
    end
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [DATA_W-1:0] seed_of(input int lane);
`ifdef PHY_GEN_PRBS_EN
        logic [7:0] s;
        s          = 8'(lane + 1);
        seed_of    = '0;
        seed_of[7:0] = s;
`else
        seed_of = DATA_W'(lane);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] next_pat(input logic [DATA_W-1:0] v);
`ifdef PHY_GEN_PRBS_EN
        logic [7:0] l;
        l             = v[7:0];
        next_pat      = '0;
        next_pat[7:0] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
`else
        next_pat = v + DATA_W'(1);
`endif
    endfunction

    state_t                         state_q, state_d;
    logic [15:0]                    sent_q, sent_d, len_q, len_d;
    logic [GW-1:0]                  gap_q, gap_d;
    logic [LANES-1:0][DATA_W-1:0]   gen_q, gen_d, exp_q, exp_d, seeds;
    logic [LANES-1:0][WW-1:0]       par_q, par_d, din;
    logic                           busy_q, busy_d, done_q, done_d;
    logic                           errf_q, errf_d;
    logic [ERR_W-1:0]               errc_q, errc_d;
    logic [RX_W-1:0]                rx_q, rx_d;
    logic                           clr;
    logic [CW-1:0]                  n_mis, n_vld;
    logic [EW-1:0]                  esum;
    logic [RW-1:0]                  rsum;

    assign din       = data_in;
    assign paralelo  = par_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_flag  = errf_q;
    assign err_count = errc_q;
    assign rx_count  = rx_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) seeds[i] = seed_of(i);
    end

    // Generator FSM. Outputs are registered from state_q, so busy rises with
    // the first word and falls as the DONE state zeroes paralelo.
    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        len_d   = len_q;
        gap_d   = gap_q;
        gen_d   = gen_q;
        par_d   = '0;
        busy_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && burst_len != 16'd0) begin
                    state_d = S_RUN;
                    sent_d  = 16'd0;
                    gap_d   = '0;
                    len_d   = burst_len;
                    gen_d   = seeds;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (GAP_PERIOD != 0 && gap_q == GW'(GP_LAST)) begin
                    // Gap word: valid low, data repeats the previous word.
                    gap_d = '0;
                    for (int i = 0; i < LANES; i++)
                        par_d[i] = {1'b0, par_q[i][DATA_W-1:0]};
                end else begin
                    if (GAP_PERIOD != 0) gap_d = gap_q + GW'(1);
                    for (int i = 0; i < LANES; i++) begin
                        par_d[i] = {1'b1, gen_q[i]};
                        gen_d[i] = next_pat(gen_q[i]);
                    end
                    sent_d = sent_q + 16'd1;
                    if (sent_d == len_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    // Checker: each lane's expected value advances only on a valid word,
    // matched or not, so one corrupt word costs exactly one error.
    always_comb begin
        n_mis = '0;
        n_vld = '0;
        exp_d = exp_q;
        for (int i = 0; i < LANES; i++) begin
            if (din[i][DATA_W]) begin
                n_vld    = n_vld + CW'(1);
                if (din[i][DATA_W-1:0] != exp_q[i]) n_mis = n_mis + CW'(1);
                exp_d[i] = next_pat(exp_q[i]);
            end
        end
        esum   = EW'(errc_q) + EW'(n_mis);
        rsum   = RW'(rx_q) + RW'(n_vld);
        errc_d = (esum > EW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : esum[ERR_W-1:0];
        rx_d   = (rsum > RW'({RX_W{1'b1}})) ? {RX_W{1'b1}} : rsum[RX_W-1:0];
        errf_d = errf_q | (n_mis != '0);
        if (clr) begin
            exp_d  = seeds;
            errc_d = '0;
            rx_d   = '0;
            errf_d = 1'b0;
        end
    end

    always_ff @(posedge clkf) begin
        if (reset) begin
            state_q <= S_IDLE;
            sent_q  <= 16'd0;
            len_q   <= 16'd0;
            gap_q   <= '0;
            gen_q   <= seeds;
            exp_q   <= seeds;
            par_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            errf_q  <= 1'b0;
            errc_q  <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gen_q   <= gen_d;
            exp_q   <= exp_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            errf_q  <= errf_d;
            errc_q  <= errc_d;
            rx_q    <= rx_d;
        end
    end

endmodule
